// File: rtl/dcache_pkg.sv
// Shared types and constants for the direct-mapped write-back data cache.
package dcache_pkg;

  localparam int ADDR_W  = 16;
  localparam int WORD_W  = 16;
  localparam int OFF_W   = 2;
  localparam int LINE_W  = 64;
  localparam int MADDR_W = 14;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    WBACK  = 2'd1,
    FILL   = 2'd2,
    REPLAY = 2'd3
  } state_e;

  function automatic logic [WORD_W-1:0] get_word(input logic [LINE_W-1:0] line,
                                                 input logic [OFF_W-1:0]  off);
    return line[off*WORD_W +: WORD_W];
  endfunction

  function automatic logic [LINE_W-1:0] put_word(input logic [LINE_W-1:0] line,
                                                 input logic [OFF_W-1:0]  off,
                                                 input logic [WORD_W-1:0] word);
    logic [LINE_W-1:0] l;
    l = line;
    l[off*WORD_W +: WORD_W] = word;
    return l;
  endfunction

endpackage

// File: rtl/dcache_if.sv
// CPU-side and memory-side signals of the data cache; slave = cache, master = pipeline + memory.
interface dcache_if;
  import dcache_pkg::*;

  logic [ADDR_W-1:0]  cpu_addr;
  logic               cpu_re;
  logic               cpu_we;
  logic [WORD_W-1:0]  cpu_wdata;
  logic [WORD_W-1:0]  cpu_rdata;
  logic               stall;
  logic [MADDR_W-1:0] mem_addr;
  logic               mem_re;
  logic               mem_we;
  logic [LINE_W-1:0]  mem_wdata;
  logic [LINE_W-1:0]  mem_rdata;
  logic               mem_rdy;

  modport slave (
    input  cpu_addr, cpu_re, cpu_we, cpu_wdata, mem_rdata, mem_rdy,
    output cpu_rdata, stall, mem_addr, mem_re, mem_we, mem_wdata
  );

  modport master (
    output cpu_addr, cpu_re, cpu_we, cpu_wdata, mem_rdata, mem_rdy,
    input  cpu_rdata, stall, mem_addr, mem_re, mem_we, mem_wdata
  );

endinterface

// File: rtl/dcache_array.sv
// Tag/valid/dirty/data storage for the data cache; combinational read, one write op per cycle.
module dcache_array
  import dcache_pkg::*;
#(
  parameter int LINES = 8,
  parameter int IDX_W = $clog2(LINES),
  parameter int TAG_W = ADDR_W - IDX_W - OFF_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [IDX_W-1:0]  idx_i,
  input  logic              word_we_i,
  input  logic [OFF_W-1:0]  off_i,
  input  logic [WORD_W-1:0] word_i,
  input  logic              fill_en_i,
  input  logic [TAG_W-1:0]  fill_tag_i,
  input  logic [LINE_W-1:0] fill_data_i,
  input  logic              dclr_en_i,
  output logic              valid_o,
  output logic              dirty_o,
  output logic [TAG_W-1:0]  tag_o,
  output logic [LINE_W-1:0] data_o
);

  logic [LINES-1:0]  valid_q;
  logic [LINES-1:0]  dirty_q;
  logic [TAG_W-1:0]  tag_q  [LINES];
  logic [LINE_W-1:0] data_q [LINES];

  assign valid_o = valid_q[idx_i];
  assign dirty_o = dirty_q[idx_i];
  assign tag_o   = tag_q[idx_i];
  assign data_o  = data_q[idx_i];

  // Status bits: the only storage that must come out of reset known.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= '0;
      dirty_q <= '0;
    end else if (fill_en_i) begin
      valid_q[idx_i] <= 1'b1;
      dirty_q[idx_i] <= 1'b0;
    end else if (word_we_i) begin
      dirty_q[idx_i] <= 1'b1;
    end else if (dclr_en_i) begin
      dirty_q[idx_i] <= 1'b0;
    end
  end

  // Tag and data payload; contents are qualified by valid so need no reset.
  always_ff @(posedge clk) begin
    if (fill_en_i) begin
      tag_q[idx_i]  <= fill_tag_i;
      data_q[idx_i] <= fill_data_i;
    end else if (word_we_i) begin
      data_q[idx_i] <= put_word(data_q[idx_i], off_i, word_i);
    end
  end

endmodule

// File: rtl/dcache_ctrl.sv
// Direct-mapped write-back/write-allocate data cache controller.
// Optional hit/miss counters are built when DCACHE_STATS_EN is defined.
module dcache_ctrl
  import dcache_pkg::*;
#(
  parameter int LINES = 8
) (
  input  logic        clk,
  input  logic        rst,
  dcache_if.slave     bus
`ifdef DCACHE_STATS_EN
  ,
  output logic [15:0] hit_cnt,
  output logic [15:0] miss_cnt
`endif
);

  localparam int IDX_W = $clog2(LINES);
  localparam int TAG_W = ADDR_W - IDX_W - OFF_W;

  state_e             state_q;
  logic               mem_re_q;
  logic               mem_we_q;
  logic [MADDR_W-1:0] mem_addr_q;
  logic [LINE_W-1:0]  mem_wdata_q;

  logic [OFF_W-1:0]   off;
  logic [IDX_W-1:0]   idx;
  logic [TAG_W-1:0]   tag;
  logic               req;
  logic               hit;
  logic               idle;
  logic               stall;
  logic               line_valid;
  logic               line_dirty;
  logic [TAG_W-1:0]   line_tag;
  logic [LINE_W-1:0]  line_data;
  logic               word_we;
  logic               fill_en;
  logic               dclr_en;

  assign off  = bus.cpu_addr[OFF_W-1:0];
  assign idx  = bus.cpu_addr[IDX_W+OFF_W-1:OFF_W];
  assign tag  = bus.cpu_addr[ADDR_W-1:IDX_W+OFF_W];
  assign req  = bus.cpu_re | bus.cpu_we;
  assign hit  = line_valid & (line_tag == tag);
  assign idle = (state_q == IDLE);

  // Reset drops any pending request at once, so stall is masked by rst too.
  assign stall   = req & ~rst & ~(idle & hit);
  assign word_we = idle & hit & bus.cpu_we;
  assign fill_en = (state_q == FILL) & bus.mem_rdy;
  assign dclr_en = (state_q == WBACK) & bus.mem_rdy;

  dcache_array #(
    .LINES (LINES)
  ) u_array (
    .clk         (clk),
    .rst         (rst),
    .idx_i       (idx),
    .word_we_i   (word_we),
    .off_i       (off),
    .word_i      (bus.cpu_wdata),
    .fill_en_i   (fill_en),
    .fill_tag_i  (tag),
    .fill_data_i (bus.mem_rdata),
    .dclr_en_i   (dclr_en),
    .valid_o     (line_valid),
    .dirty_o     (line_dirty),
    .tag_o       (line_tag),
    .data_o      (line_data)
  );

  // Miss sequencer; memory-side outputs are registered and held until mem_rdy.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      mem_re_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (req && !hit) begin
            if (line_valid && line_dirty) begin
              state_q     <= WBACK;
              mem_we_q    <= 1'b1;
              mem_addr_q  <= {line_tag, idx};
              mem_wdata_q <= line_data;
            end else begin
              state_q    <= FILL;
              mem_re_q   <= 1'b1;
              mem_addr_q <= {tag, idx};
            end
          end
        end
        WBACK: begin
          if (bus.mem_rdy) begin
            state_q    <= FILL;
            mem_we_q   <= 1'b0;
            mem_re_q   <= 1'b1;
            mem_addr_q <= {tag, idx};
          end
        end
        FILL: begin
          if (bus.mem_rdy) begin
            state_q  <= REPLAY;
            mem_re_q <= 1'b0;
          end
        end
        REPLAY: begin
          state_q <= IDLE;
        end
        default: begin
          state_q  <= IDLE;
          mem_re_q <= 1'b0;
          mem_we_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.stall     = stall;
  assign bus.cpu_rdata = (bus.cpu_re && !stall && !rst) ? get_word(line_data, off) : '0;
  assign bus.mem_re    = mem_re_q;
  assign bus.mem_we    = mem_we_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;

`ifdef DCACHE_STATS_EN
  logic        replay_q;
  logic [15:0] hit_cnt_q;
  logic [15:0] hit_cnt_d;
  logic [15:0] miss_cnt_q;
  logic [15:0] miss_cnt_d;

  // The access completing right after REPLAY was already counted as a miss.
  always_comb begin
    hit_cnt_d  = hit_cnt_q;
    miss_cnt_d = miss_cnt_q;
    if (idle && req && hit && !replay_q && (hit_cnt_q != 16'hFFFF)) begin
      hit_cnt_d = hit_cnt_q + 16'd1;
    end else begin
      hit_cnt_d = hit_cnt_q;
    end
    if (idle && req && !hit && (miss_cnt_q != 16'hFFFF)) begin
      miss_cnt_d = miss_cnt_q + 16'd1;
    end else begin
      miss_cnt_d = miss_cnt_q;
    end
  end

  // Saturating statistics counters.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      replay_q   <= 1'b0;
      hit_cnt_q  <= 16'd0;
      miss_cnt_q <= 16'd0;
    end else begin
      replay_q   <= (state_q == REPLAY);
      hit_cnt_q  <= hit_cnt_d;
      miss_cnt_q <= miss_cnt_d;
    end
  end

  assign hit_cnt  = hit_cnt_q;
  assign miss_cnt = miss_cnt_q;
`endif

endmodule

// File: tb/tb_dcache_ctrl.sv
// Random + directed bench for dcache_ctrl against a flat-memory reference model.
module tb_dcache_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  dcache_if bus();

`ifdef DCACHE_STATS_EN
  logic [15:0] hit_cnt;
  logic [15:0] miss_cnt;
  int          hits_m   = 0;
  int          misses_m = 0;
`endif

  dcache_ctrl #(.LINES(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
`ifdef DCACHE_STATS_EN
    ,
    .hit_cnt  (hit_cnt),
    .miss_cnt (miss_cnt)
`endif
  );

  int checks   = 0;
  int failures = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Backing memory (line granular) and the architectural view of every word.
  logic [63:0] main_mem [16384];
  logic [15:0] ref_mem  [65536];
  bit          mvalid   [8];
  bit          mdirty   [8];
  logic [10:0] mtag     [8];

  int          mem_cycles = 0;
  int          wb_seen    = 0;
  int          d          = 2;
  logic [13:0] exp_wb_addr;
  logic [13:0] exp_fill_addr;

  function automatic logic [63:0] ref_line(input logic [13:0] la);
    return {ref_mem[{la, 2'd3}], ref_mem[{la, 2'd2}], ref_mem[{la, 2'd1}], ref_mem[{la, 2'd0}]};
  endfunction

  task automatic rebuild_ref();
    for (int l = 0; l < 16384; l++) begin
      logic [63:0] v;
      v = main_mem[l];
      for (int w = 0; w < 4; w++) ref_mem[l*4+w] = v[w*16 +: 16];
    end
    for (int i = 0; i < 8; i++) begin
      mvalid[i] = 1'b0;
      mdirty[i] = 1'b0;
    end
`ifdef DCACHE_STATS_EN
    hits_m   = 0;
    misses_m = 0;
`endif
  endtask

  // Memory responder: answers each transaction after d cycles with a one-cycle mem_rdy.
  initial begin
    int cnt;
    cnt = 0;
    bus.mem_rdy   = 1'b0;
    bus.mem_rdata = '0;
    forever begin
      @(negedge clk);
      if (bus.mem_rdy) begin
        bus.mem_rdy = 1'b0;
        cnt = 0;
      end
      check_eq("mem_excl", {63'd0, bus.mem_re & bus.mem_we}, 64'd0);
      if (rst) begin
        cnt = 0;
      end else if (bus.mem_re || bus.mem_we) begin
        cnt++;
        mem_cycles++;
        if (cnt >= d) begin
          if (bus.mem_we) begin
            wb_seen++;
            check_eq("wb_addr", {50'd0, bus.mem_addr}, {50'd0, exp_wb_addr});
            check_eq("wb_data", bus.mem_wdata, ref_line(bus.mem_addr));
            main_mem[bus.mem_addr] = bus.mem_wdata;
          end else begin
            check_eq("fill_addr", {50'd0, bus.mem_addr}, {50'd0, exp_fill_addr});
            bus.mem_rdata = main_mem[bus.mem_addr];
          end
          bus.mem_rdy = 1'b1;
          d = $urandom_range(1, 4);
        end
      end else begin
        cnt = 0;
      end
    end
  end

  task automatic do_access(input logic [15:0] a, input bit re, input bit we, input logic [15:0] wd);
    logic [2:0]  idx;
    logic [10:0] tg;
    bit          hit;
    bit          wb;
    int          m0;
    int          w0;
    int          n;
    idx = a[4:2];
    tg  = a[15:5];
    hit = mvalid[idx] && (mtag[idx] == tg);
    wb  = !hit && mvalid[idx] && mdirty[idx];
    exp_wb_addr   = {mtag[idx], idx};
    exp_fill_addr = a[15:2];
    m0 = mem_cycles;
    w0 = wb_seen;
    bus.cpu_addr  = a;
    bus.cpu_re    = re;
    bus.cpu_we    = we;
    bus.cpu_wdata = wd;
    n = 0;
    @(negedge clk);
    while (bus.stall === 1'b1 && n < 60) begin
      n++;
      @(negedge clk);
    end
    check_eq("stall_end", {63'd0, bus.stall}, 64'd0);
    check_eq("stall_cycles", n, hit ? 0 : 2 + (mem_cycles - m0));
    check_eq("wb_count", wb_seen - w0, {63'd0, wb});
    check_eq("rdata", {48'd0, bus.cpu_rdata}, re ? {48'd0, ref_mem[a]} : 64'd0);
`ifdef DCACHE_STATS_EN
    if (hit) begin
      if (hits_m < 65535) hits_m++;
    end else begin
      if (misses_m < 65535) misses_m++;
    end
`endif
    @(posedge clk);
    #1;
    if (!hit) begin
      mvalid[idx] = 1'b1;
      mtag[idx]   = tg;
      mdirty[idx] = 1'b0;
    end
    if (we) begin
      ref_mem[a]  = wd;
      mdirty[idx] = 1'b1;
    end
`ifdef DCACHE_STATS_EN
    check_eq("hit_cnt", {48'd0, hit_cnt}, hits_m);
    check_eq("miss_cnt", {48'd0, miss_cnt}, misses_m);
`endif
    bus.cpu_re = 1'b0;
    bus.cpu_we = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check_eq({tag, "_stall"}, {63'd0, bus.stall}, 64'd0);
    check_eq({tag, "_mem_re"}, {63'd0, bus.mem_re}, 64'd0);
    check_eq({tag, "_mem_we"}, {63'd0, bus.mem_we}, 64'd0);
    check_eq({tag, "_mem_addr"}, {50'd0, bus.mem_addr}, 64'd0);
    check_eq({tag, "_mem_wdata"}, bus.mem_wdata, 64'd0);
    check_eq({tag, "_rdata"}, {48'd0, bus.cpu_rdata}, 64'd0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    bus.cpu_re = 1'b0;
    bus.cpu_we = 1'b0;
    repeat (2) @(negedge clk);
    check_reset_outputs("rst");
    rebuild_ref();
    rst = 1'b0;
    @(posedge clk);
    #1;
  endtask

  initial begin
    #3000000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int k;
    bus.cpu_addr  = '0;
    bus.cpu_re    = 1'b0;
    bus.cpu_we    = 1'b0;
    bus.cpu_wdata = '0;
    for (int l = 0; l < 16384; l++) main_mem[l] = {$urandom, $urandom};
    main_mem[14'h0004] = 64'h000D_000C_000B_000A;
    do_reset();

    // Cold load, store hit, dirty and clean evictions, top-of-address index wrap.
    d = 3;
    do_access(16'h0010, 1'b1, 1'b0, 16'h0000);
    do_access(16'h0011, 1'b0, 1'b1, 16'h1234);
    do_access(16'h0011, 1'b1, 1'b0, 16'h0000);
    do_access(16'h0030, 1'b1, 1'b0, 16'h0000);
    do_access(16'h0020, 1'b1, 1'b0, 16'h0000);
    do_access(16'h00A0, 1'b1, 1'b0, 16'h0000);
    do_access(16'hFFFF, 1'b0, 1'b1, 16'hBEEF);
    do_access(16'h001C, 1'b1, 1'b0, 16'h0000);
    do_access(16'hFFFF, 1'b1, 1'b0, 16'h0000);

    // Reset in the middle of a fill.
    do_reset();
    d = 50;
    bus.cpu_addr = 16'h0040;
    bus.cpu_re   = 1'b1;
    k = 0;
    while (bus.mem_re !== 1'b1 && k < 20) begin
      k++;
      @(negedge clk);
    end
    check_eq("rmf_fill_started", {63'd0, bus.mem_re}, 64'd1);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check_reset_outputs("rmf");
    @(negedge clk);
    bus.cpu_re = 1'b0;
    rebuild_ref();
    d = 2;
    rst = 1'b0;
    @(posedge clk);
    #1;
    do_access(16'h0040, 1'b1, 1'b0, 16'h0000);

`ifdef DCACHE_STATS_EN
    do_reset();
    do_access(16'h0044, 1'b1, 1'b0, 16'h0000);
    do_access(16'h0008, 1'b1, 1'b0, 16'h0000);
    do_access(16'h0045, 1'b1, 1'b0, 16'h0000);
    do_access(16'h0009, 1'b0, 1'b1, 16'h5A5A);
    do_access(16'h0046, 1'b1, 1'b0, 16'h0000);
    for (int i = 0; i < 65540; i++) do_access(16'h0047, 1'b1, 1'b0, 16'h0000);
`endif

    // Random mix over a small address window plus the top of the address space.
    for (int i = 0; i < 400; i++) begin
      logic [15:0] a;
      int          op;
      a = 16'($urandom_range(0, 127));
      if ($urandom_range(0, 9) == 0) a = 16'hFFFF - 16'($urandom_range(0, 7));
      op = $urandom_range(0, 2);
      do_access(a, op != 1, op != 0, 16'($urandom));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
